// File: rtl/grf_wb_arbiter.sv
// Single GRF write-port arbiter: pipeline writeback has priority, long-latency results wait in a 4-entry FIFO.
// Optional macro GRF_ARB_BYPASS_EN lets a secondary result skip the empty FIFO when the port is free.
module grf_wb_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  input  logic        ld_valid,
  input  logic [4:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic [31:0] ld_pc,
  output logic        ld_ready,
  output logic        grf_we,
  output logic [4:0]  grf_addr,
  output logic [31:0] grf_wdata,
  output logic [31:0] grf_pc,
  input  logic [4:0]  rd_addr_a,
  input  logic [4:0]  rd_addr_b,
  output logic        pend_a,
  output logic        pend_b,
  output logic [2:0]  buf_count
);

  localparam int DEPTH = 4;

  logic [4:0]       addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];
  logic [DEPTH-1:0] live_reg;
  logic [1:0]       rd_ptr_reg, wr_ptr_reg;
  logic [2:0]       count_reg;

  logic wb_grant, empty, full, ld_accept, ld_nonzero, collide, bypass, enq, deq;

  assign wb_grant   = wb_valid && (wb_addr != 5'd0);
  assign empty      = (count_reg == 3'd0);
  assign full       = (count_reg == 3'd4);
  assign ld_ready   = !full;
  assign ld_accept  = ld_valid && ld_ready;
  assign ld_nonzero = (ld_addr != 5'd0);
  assign collide    = wb_grant && (ld_addr == wb_addr);

`ifdef GRF_ARB_BYPASS_EN
  // No wb grant here, so a bypassed request can never collide with a wb write.
  assign bypass = ld_accept && ld_nonzero && !wb_grant && empty;
`else
  assign bypass = 1'b0;
`endif

  assign enq       = ld_accept && ld_nonzero && !bypass;
  assign deq       = !wb_grant && !empty;
  assign buf_count = count_reg;

  always_comb begin
    grf_we    = 1'b0;
    grf_addr  = 5'd0;
    grf_wdata = 32'd0;
    grf_pc    = 32'd0;
    if (wb_grant) begin
      grf_we    = 1'b1;
      grf_addr  = wb_addr;
      grf_wdata = wb_data;
      grf_pc    = wb_pc;
    end else if (!empty) begin
      grf_we    = live_reg[rd_ptr_reg];
      grf_addr  = addr_mem[rd_ptr_reg];
      grf_wdata = data_mem[rd_ptr_reg];
      grf_pc    = pc_mem[rd_ptr_reg];
    end else if (bypass) begin
      grf_we    = 1'b1;
      grf_addr  = ld_addr;
      grf_wdata = ld_data;
      grf_pc    = ld_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr_reg] <= ld_addr;
      data_mem[wr_ptr_reg] <= ld_data;
      pc_mem[wr_ptr_reg]   <= ld_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= 2'd0;
      wr_ptr_reg <= 2'd0;
      count_reg  <= 3'd0;
      live_reg   <= '0;
    end else begin
      // A wb write supersedes every older buffered result for the same register.
      if (wb_grant) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (addr_mem[i] == wb_addr) live_reg[i] <= 1'b0;
        end
      end
      if (enq) begin
        live_reg[wr_ptr_reg] <= !collide;
        wr_ptr_reg           <= wr_ptr_reg + 2'd1;
      end
      if (deq) rd_ptr_reg <= rd_ptr_reg + 2'd1;
      count_reg <= count_reg + {2'b00, enq} - {2'b00, deq};
    end
  end

  logic [DEPTH-1:0] hit_a, hit_b;
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [1:0] offset;
      logic       occupied;
      assign offset     = 2'(gi) - rd_ptr_reg;
      assign occupied   = ({1'b0, offset} < count_reg) && live_reg[gi];
      assign hit_a[gi]  = occupied && (addr_mem[gi] == rd_addr_a);
      assign hit_b[gi]  = occupied && (addr_mem[gi] == rd_addr_b);
    end
  endgenerate

  assign pend_a = (|hit_a) && (rd_addr_a != 5'd0);
  assign pend_b = (|hit_b) && (rd_addr_b != 5'd0);

endmodule
